// File: rtl/turn_scheduler.sv
// turn_scheduler: sequences one tic-tac-toe game (turn order, move grant, winner check, CPU/auto placement).
// Optional feature macro TURN_TIMEOUT_EN enables the per-turn timer and timeout auto-placement.
module turn_scheduler #(
   parameter int unsigned TURN_CYCLES = 500,
   parameter int unsigned CNT_W       = 10
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       first_p2_i,
   input  logic       two_player_i,
   input  logic       p1_req_i,
   input  logic       p2_req_i,
   input  logic [1:0] p1_row_i,
   input  logic [1:0] p1_col_i,
   input  logic [1:0] p2_row_i,
   input  logic [1:0] p2_col_i,
   input  logic [3:0] rand_idx_i,
   input  logic [8:0] cell_busy_i,
   input  logic [1:0] winner_i,
   output logic       wr_en_o,
   output logic [1:0] wr_row_o,
   output logic [1:0] wr_col_o,
   output logic [1:0] wr_player_o,
   output logic       check_en_o,
   output logic [1:0] current_player_o,
   output logic       timeout_o,
   output logic       illegal_o,
   output logic [3:0] turn_count_o,
   output logic [3:0] state_o
);

   if ((64'd1 << CNT_W) <= 64'(TURN_CYCLES)) begin : g_bad_cnt_w
      $error("CNT_W too narrow to count TURN_CYCLES");
   end

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_P1    = 4'd1,
      S_P2    = 4'd2,
      S_SCAN  = 4'd4,
      S_WRITE = 4'd5,
      S_CHECK = 4'd6,
      S_EVAL  = 4'd7,
      S_OVER  = 4'd8
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] cur_q, cur_d;
   logic [3:0] cnt_q, cnt_d;
   logic       two_q, two_d;
   logic [3:0] idx_q, idx_d;
   logic [3:0] scnt_q, scnt_d;
   logic       wr_en_q, wr_en_d;
   logic [1:0] wr_row_q, wr_row_d;
   logic [1:0] wr_col_q, wr_col_d;
   logic [1:0] wr_player_q, wr_player_d;
   logic       check_en_q, check_en_d;
   logic       timeout_q, timeout_d;
   logic       illegal_q, illegal_d;

   logic       in_turn_c, req_c, legal_c, expired_c;
   logic [1:0] req_row_c, req_col_c;
   logic [3:0] req_idx_c;

   function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
      return 4'(({2'b00, row} - 4'd1) * 4'd3) + ({2'b00, col} - 4'd1);
   endfunction

   // Only the player whose turn it is gets a say
   assign in_turn_c = (state_q == S_P1) || (state_q == S_P2);
   assign req_c     = (state_q == S_P1) ? p1_req_i : ((state_q == S_P2) ? p2_req_i : 1'b0);
   assign req_row_c = (state_q == S_P2) ? p2_row_i : p1_row_i;
   assign req_col_c = (state_q == S_P2) ? p2_col_i : p1_col_i;
   assign req_idx_c = cell_idx(req_row_c, req_col_c);
   assign legal_c   = req_c && (req_row_c != 2'd0) && (req_col_c != 2'd0) && !cell_busy_i[req_idx_c];

`ifdef TURN_TIMEOUT_EN
   logic [CNT_W-1:0] timer_q;

   // Restarts on every turn entry; an illegal request does not reset it
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         timer_q <= '0;
      end else if (in_turn_c && (state_d == state_q)) begin
         timer_q <= timer_q + CNT_W'(1);
      end else begin
         timer_q <= '0;
      end
   end

   assign expired_c = in_turn_c && (timer_q == CNT_W'(TURN_CYCLES - 1));
`else
   assign expired_c = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      cnt_d       = cnt_q;
      two_d       = two_q;
      idx_d       = (state_q == S_SCAN) ? idx_q : 4'(rand_idx_i % 4'd9);
      scnt_d      = '0;
      wr_en_d     = 1'b0;
      wr_row_d    = '0;
      wr_col_d    = '0;
      wr_player_d = '0;
      check_en_d  = 1'b0;
      timeout_d   = 1'b0;
      illegal_d   = 1'b0;

      case (state_q)
         S_IDLE, S_OVER: begin
            if (start_i) begin
               two_d = two_player_i;
               cnt_d = '0;
               if (first_p2_i) begin
                  cur_d   = 2'd2;
                  state_d = two_player_i ? S_P2 : S_SCAN;
               end else begin
                  cur_d   = 2'd1;
                  state_d = S_P1;
               end
            end
         end
         S_P1, S_P2: begin
            if (legal_c) begin
               state_d     = S_WRITE;
               wr_en_d     = 1'b1;
               wr_row_d    = req_row_c;
               wr_col_d    = req_col_c;
               wr_player_d = cur_q;
            end else begin
               illegal_d = req_c;
               if (expired_c) begin
                  timeout_d = 1'b1;
                  state_d   = S_SCAN;
               end
            end
         end
         // One cell per cycle from the seed, wrapping 8->0; nine busy cells means a full board
         S_SCAN: begin
            if (!cell_busy_i[idx_q]) begin
               state_d     = S_WRITE;
               wr_en_d     = 1'b1;
               wr_row_d    = 2'(idx_q / 4'd3) + 2'd1;
               wr_col_d    = 2'(idx_q % 4'd3) + 2'd1;
               wr_player_d = cur_q;
            end else if (scnt_q == 4'd8) begin
               state_d = S_OVER;
            end else begin
               idx_d  = (idx_q == 4'd8) ? 4'd0 : idx_q + 4'd1;
               scnt_d = scnt_q + 4'd1;
            end
         end
         S_WRITE: begin
            cnt_d      = cnt_q + 4'd1;
            check_en_d = 1'b1;
            state_d    = S_CHECK;
         end
         S_CHECK: begin
            state_d = S_EVAL;
         end
         S_EVAL: begin
            if ((winner_i != 2'd0) || (cnt_q == 4'd9)) begin
               state_d = S_OVER;
            end else if (cur_q == 2'd1) begin
               cur_d   = 2'd2;
               state_d = two_q ? S_P2 : S_SCAN;
            end else begin
               cur_d   = 2'd1;
               state_d = S_P1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         cnt_q       <= '0;
         two_q       <= 1'b0;
         idx_q       <= '0;
         scnt_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_row_q    <= '0;
         wr_col_q    <= '0;
         wr_player_q <= '0;
         check_en_q  <= 1'b0;
         timeout_q   <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         cnt_q       <= cnt_d;
         two_q       <= two_d;
         idx_q       <= idx_d;
         scnt_q      <= scnt_d;
         wr_en_q     <= wr_en_d;
         wr_row_q    <= wr_row_d;
         wr_col_q    <= wr_col_d;
         wr_player_q <= wr_player_d;
         check_en_q  <= check_en_d;
         timeout_q   <= timeout_d;
         illegal_q   <= illegal_d;
      end
   end

   assign wr_en_o          = wr_en_q;
   assign wr_row_o         = wr_row_q;
   assign wr_col_o         = wr_col_q;
   assign wr_player_o      = wr_player_q;
   assign check_en_o       = check_en_q;
   assign current_player_o = cur_q;
   assign timeout_o        = timeout_q;
   assign illegal_o        = illegal_q;
   assign turn_count_o     = cnt_q;
   assign state_o          = 4'(state_q);

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler: scenario tasks plus a write scoreboard.
module tb_turn_scheduler;

   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
      logic [1:0] player;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, first_p2 = 1'b0, two_player = 1'b1;
   logic       p1_req = 1'b0, p2_req = 1'b0;
   logic [1:0] p1_row = '0, p1_col = '0, p2_row = '0, p2_col = '0;
   logic [3:0] rand_idx = '0;
   logic [8:0] cell_busy = '0;
   logic [1:0] winner = '0;
   logic       wr_en, check_en, timeout, illegal;
   logic [1:0] wr_row, wr_col, wr_player, cur;
   logic [3:0] turn_count, state;

   int  checks = 0;
   int  errors = 0;
   wr_t exp_q[$];
   wr_t exp_w;

   turn_scheduler #(.TURN_CYCLES(8), .CNT_W(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .first_p2_i(first_p2),
      .two_player_i(two_player), .p1_req_i(p1_req), .p2_req_i(p2_req),
      .p1_row_i(p1_row), .p1_col_i(p1_col), .p2_row_i(p2_row), .p2_col_i(p2_col),
      .rand_idx_i(rand_idx), .cell_busy_i(cell_busy), .winner_i(winner),
      .wr_en_o(wr_en), .wr_row_o(wr_row), .wr_col_o(wr_col), .wr_player_o(wr_player),
      .check_en_o(check_en), .current_player_o(cur), .timeout_o(timeout),
      .illegal_o(illegal), .turn_count_o(turn_count), .state_o(state)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   // Every observed write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write got row=%0d col=%0d player=%0d", wr_row, wr_col, wr_player);
         end else begin
            exp_w = exp_q.pop_front();
            if ({wr_row, wr_col, wr_player} !== exp_w) begin
               errors++;
               $display("FAIL write got row=%0d col=%0d player=%0d exp row=%0d col=%0d player=%0d",
                        wr_row, wr_col, wr_player, exp_w.row, exp_w.col, exp_w.player);
            end
         end
      end
   end

   function automatic wr_t mk(input int r, input int c, input int p);
      wr_t w;
      w.row = 2'(r); w.col = 2'(c); w.player = 2'(p);
      return w;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_game(input logic fp2, input logic two);
      first_p2 = fp2; two_player = two; start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(2);
      checks++;
      if ({wr_en, wr_row, wr_col, wr_player, check_en, cur, timeout, illegal, turn_count, state} !== 20'd0) begin
         errors++; $display("FAIL reset_outputs state=%0d cur=%0d cnt=%0d wr_en=%0d exp all 0", state, cur, turn_count, wr_en);
      end
      rst_n = 1'b1;
      tick(1);
      start_game(1'b0, 1'b1);
      checks++;
      if (state !== 4'd1 || cur !== 2'd1) begin
         errors++; $display("FAIL start_p1 state=%0d cur=%0d exp 1/1", state, cur);
      end
   endtask

   task automatic test_legal_move();
      p1_row = 2'd2; p1_col = 2'd3; cell_busy = '0; p1_req = 1'b1;
      exp_q.push_back(mk(2, 3, 1));
      tick(1);
      p1_req = 1'b0;
      checks++;
      if (state !== 4'd5 || wr_en !== 1'b1) begin
         errors++; $display("FAIL legal_write state=%0d wr_en=%0d exp 5/1", state, wr_en);
      end
      tick(1);
      checks++;
      if (state !== 4'd6 || check_en !== 1'b1 || turn_count !== 4'd1) begin
         errors++; $display("FAIL check_strobe state=%0d check_en=%0d cnt=%0d exp 6/1/1", state, check_en, turn_count);
      end
      tick(2);
      checks++;
      if (state !== 4'd2 || cur !== 2'd2) begin
         errors++; $display("FAIL toggle_p2 state=%0d cur=%0d exp 2/2", state, cur);
      end
      p2_row = 2'd1; p2_col = 2'd1; p2_req = 1'b1;
      exp_q.push_back(mk(1, 1, 2));
      tick(1);
      p2_req = 1'b0;
      tick(3);
      checks++;
      if (state !== 4'd1 || cur !== 2'd1 || turn_count !== 4'd2) begin
         errors++; $display("FAIL back_to_p1 state=%0d cur=%0d cnt=%0d exp 1/1/2", state, cur, turn_count);
      end
   endtask

   task automatic test_illegal();
      p1_row = 2'd0; p1_col = 2'd1; p1_req = 1'b1;
      tick(1);
      checks++;
      if (illegal !== 1'b1 || state !== 4'd1 || wr_en !== 1'b0) begin
         errors++; $display("FAIL illegal_row0 illegal=%0d state=%0d wr_en=%0d exp 1/1/0", illegal, state, wr_en);
      end
      p1_req = 1'b0;
      tick(1);
      checks++;
      if (illegal !== 1'b0) begin
         errors++; $display("FAIL illegal_pulse illegal=%0d exp 0", illegal);
      end
      p1_row = 2'd2; p1_col = 2'd2; cell_busy = 9'h010; p1_req = 1'b1;
      tick(1);
      checks++;
      if (illegal !== 1'b1 || state !== 4'd1) begin
         errors++; $display("FAIL illegal_busy illegal=%0d state=%0d exp 1/1", illegal, state);
      end
      p1_req = 1'b0; cell_busy = '0;
      p2_row = 2'd1; p2_col = 2'd2; p2_req = 1'b1;
      tick(1);
      checks++;
      if (illegal !== 1'b0 || state !== 4'd1 || wr_en !== 1'b0) begin
         errors++; $display("FAIL p2_ignored illegal=%0d state=%0d wr_en=%0d exp 0/1/0", illegal, state, wr_en);
      end
      p2_req = 1'b0;
      p1_row = 2'd3; p1_col = 2'd3; p1_req = 1'b1;
      exp_q.push_back(mk(3, 3, 1));
      tick(1);
      p1_req = 1'b0;
      tick(3);
      checks++;
      if (state !== 4'd2) begin
         errors++; $display("FAIL after_illegal state=%0d exp 2", state);
      end
   endtask

   task automatic test_timeout();
      int bad = 0;
      rand_idx = 4'd13; cell_busy = 9'h030;
`ifdef TURN_TIMEOUT_EN
      exp_q.push_back(mk(3, 1, 2));
      for (int i = 1; i < 8; i++) begin
         tick(1);
         if (timeout !== 1'b0 || state !== 4'd2) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL early_timeout bad_cycles=%0d exp 0", bad);
      end
      tick(1);
      checks++;
      if (timeout !== 1'b1 || state !== 4'd4) begin
         errors++; $display("FAIL timeout_pulse timeout=%0d state=%0d exp 1/4", timeout, state);
      end
      tick(2);
      checks++;
      if (state !== 4'd4 || timeout !== 1'b0) begin
         errors++; $display("FAIL scan_busy state=%0d timeout=%0d exp 4/0", state, timeout);
      end
      tick(1);
      checks++;
      if (state !== 4'd5) begin
         errors++; $display("FAIL scan_found state=%0d exp 5", state);
      end
`else
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (timeout !== 1'b0 || state !== 4'd2) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL no_timeout bad_cycles=%0d exp 0", bad);
      end
      p2_row = 2'd3; p2_col = 2'd1; p2_req = 1'b1;
      exp_q.push_back(mk(3, 1, 2));
      tick(1);
      p2_req = 1'b0;
`endif
      cell_busy = '0;
      tick(3);
      checks++;
      if (state !== 4'd1 || cur !== 2'd1) begin
         errors++; $display("FAIL after_timeout state=%0d cur=%0d exp 1/1", state, cur);
      end
   endtask

   task automatic test_game_end();
      p1_row = 2'd1; p1_col = 2'd2; p1_req = 1'b1;
      exp_q.push_back(mk(1, 2, 1));
      tick(1);
      p1_req = 1'b0;
      tick(1);
      winner = 2'd1;
      tick(2);
      winner = 2'd0;
      checks++;
      if (state !== 4'd8 || cur !== 2'd1 || turn_count !== 4'd5) begin
         errors++; $display("FAIL winner_over state=%0d cur=%0d cnt=%0d exp 8/1/5", state, cur, turn_count);
      end
   endtask

   task automatic test_single_player();
      rand_idx = 4'd0; cell_busy = '0;
      exp_q.push_back(mk(1, 1, 2));
      start_game(1'b1, 1'b0);
      checks++;
      if (state !== 4'd4 || cur !== 2'd2 || turn_count !== 4'd0) begin
         errors++; $display("FAIL cpu_first state=%0d cur=%0d cnt=%0d exp 4/2/0", state, cur, turn_count);
      end
      tick(4);
      checks++;
      if (state !== 4'd1 || cur !== 2'd1) begin
         errors++; $display("FAIL cpu_to_p1 state=%0d cur=%0d exp 1/1", state, cur);
      end
      p1_row = 2'd2; p1_col = 2'd2; p1_req = 1'b1;
      exp_q.push_back(mk(2, 2, 1));
      tick(1);
      p1_req = 1'b0;
      exp_q.push_back(mk(1, 1, 2));
      tick(3);
      checks++;
      if (state !== 4'd4 || cur !== 2'd2) begin
         errors++; $display("FAIL p1_to_cpu state=%0d cur=%0d exp 4/2", state, cur);
      end
      tick(4);
      checks++;
      if (state !== 4'd1 || turn_count !== 4'd3) begin
         errors++; $display("FAIL cpu_second state=%0d cnt=%0d exp 1/3", state, turn_count);
      end
   endtask

   task automatic test_scan_full();
      p1_row = 2'd3; p1_col = 2'd2; p1_req = 1'b1;
      exp_q.push_back(mk(3, 2, 1));
      tick(1);
      p1_req = 1'b0; winner = 2'd1;
      tick(3);
      winner = 2'd0;
      cell_busy = 9'h1FF; rand_idx = 4'd7;
      start_game(1'b1, 1'b0);
      tick(8);
      checks++;
      if (state !== 4'd4) begin
         errors++; $display("FAIL full_scan_len state=%0d exp 4", state);
      end
      tick(1);
      checks++;
      if (state !== 4'd8 || turn_count !== 4'd0 || cur !== 2'd2) begin
         errors++; $display("FAIL full_board state=%0d cnt=%0d cur=%0d exp 8/0/2", state, turn_count, cur);
      end
      cell_busy = '0;
   endtask

   task automatic test_nine_writes();
      logic [3:0] exp_state;
      start_game(1'b0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         if (i % 2 == 0) begin
            p1_row = 2'(i / 3 + 1); p1_col = 2'(i % 3 + 1); p1_req = 1'b1;
            exp_q.push_back(mk(i / 3 + 1, i % 3 + 1, 1));
         end else begin
            p2_row = 2'(i / 3 + 1); p2_col = 2'(i % 3 + 1); p2_req = 1'b1;
            exp_q.push_back(mk(i / 3 + 1, i % 3 + 1, 2));
         end
         tick(1);
         p1_req = 1'b0; p2_req = 1'b0;
         tick(3);
         exp_state = (i == 8) ? 4'd8 : ((i % 2 == 0) ? 4'd2 : 4'd1);
         checks++;
         if (state !== exp_state || turn_count !== 4'(i + 1)) begin
            errors++; $display("FAIL nine_writes move=%0d state=%0d cnt=%0d exp %0d/%0d", i, state, turn_count, exp_state, i + 1);
         end
      end
   endtask

   task automatic test_reset_mid_write();
      start_game(1'b0, 1'b1);
      p1_row = 2'd1; p1_col = 2'd1; p1_req = 1'b1;
      tick(1);
      p1_req = 1'b0;
      checks++;
      if (state !== 4'd5 || wr_en !== 1'b1) begin
         errors++; $display("FAIL pre_reset state=%0d wr_en=%0d exp 5/1", state, wr_en);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({wr_en, wr_row, wr_col, wr_player, check_en, cur, timeout, illegal, turn_count, state} !== 20'd0) begin
         errors++; $display("FAIL async_reset state=%0d cur=%0d wr_en=%0d exp all 0", state, cur, wr_en);
      end
      tick(1);
      rst_n = 1'b1;
      tick(2);
      checks++;
      if (state !== 4'd0 || cur !== 2'd0) begin
         errors++; $display("FAIL idle_after_reset state=%0d cur=%0d exp 0/0", state, cur);
      end
   endtask

   initial begin
      test_reset();
      test_legal_move();
      test_illegal();
      test_timeout();
      test_game_end();
      test_single_player();
      test_scan_full();
      test_nine_writes();
      test_reset_mid_write();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL missing_writes pending=%0d exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
